// File: rtl/pe_pkg.sv
// Shared types and the saturating adder for the pe_vec_mac column PE.
// Saturation is enabled by defining PE_VEC_MAC_SAT_EN in the lane/top builds.
package pe_pkg;

  typedef enum logic [1:0] {
    MODE_MAC   = 2'd0,
    MODE_BIAS  = 2'd1,
    MODE_DRAIN = 2'd2,
    MODE_IDLE  = 2'd3
  } pe_mode_e;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_DRAIN = 1'b1
  } pe_state_e;

  localparam int SAT_MAX_W = 64;
  localparam int SAT_EXT_W = SAT_MAX_W + 1;

  typedef struct packed {
    logic signed [SAT_MAX_W-1:0] sum;
    logic                        clip;
  } sat_res_t;

  // Adds two sign-extended operands and clips to the signed range of `width` bits.
  function automatic sat_res_t sat_add(input logic signed [SAT_MAX_W-1:0] a,
                                       input logic signed [SAT_MAX_W-1:0] b,
                                       input int unsigned                 width);
    logic signed [SAT_EXT_W-1:0] full;
    logic signed [SAT_EXT_W-1:0] hi;
    logic signed [SAT_EXT_W-1:0] lo;
    sat_res_t                    r;
    full = SAT_EXT_W'(a) + SAT_EXT_W'(b);
    hi   = (SAT_EXT_W'(1) <<< (width - 1)) - SAT_EXT_W'(1);
    lo   = -hi - SAT_EXT_W'(1);
    r.clip = 1'b0;
    r.sum  = full[SAT_MAX_W-1:0];
    if (full > hi) begin
      r.sum  = hi[SAT_MAX_W-1:0];
      r.clip = 1'b1;
    end else if (full < lo) begin
      r.sum  = lo[SAT_MAX_W-1:0];
      r.clip = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pe_mac_lane.sv
// One signed MAC lane: accumulate, bias-load and clear, wrapping or (with
// PE_VEC_MAC_SAT_EN defined) saturating, with a single-cycle overflow pulse.
module pe_mac_lane
  import pe_pkg::*;
#(
  parameter int WIDTH_DATA  = 16,
  parameter int WIDTH_MDATA = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          mac_i,
  input  logic                          bias_i,
  input  logic                          clr_i,
  input  logic signed [WIDTH_DATA-1:0]  v_i,
  input  logic signed [WIDTH_DATA-1:0]  h_i,
  output logic signed [WIDTH_MDATA-1:0] acc_o,
  output logic                          ovf_o
);

  logic signed [2*WIDTH_DATA-1:0]  prod;
  logic signed [WIDTH_MDATA-1:0]   acc_q;
  logic signed [WIDTH_MDATA-1:0]   acc_d;

  assign prod = v_i * h_i;

`ifdef PE_VEC_MAC_SAT_EN
  sat_res_t add_r;
  assign add_r = sat_add(SAT_MAX_W'(acc_q), SAT_MAX_W'(prod), WIDTH_MDATA);
`endif

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
  always_comb begin
    acc_d = acc_q;
    ovf_o = 1'b0;
    if (clr_i) begin
      acc_d = '0;
    end else if (bias_i) begin
      acc_d = WIDTH_MDATA'(v_i);
    end else if (mac_i) begin
`ifdef PE_VEC_MAC_SAT_EN
      acc_d = add_r.sum[WIDTH_MDATA-1:0];
      ovf_o = add_r.clip;
`else
      acc_d = acc_q + WIDTH_MDATA'(prod);
`endif
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/pe_vec_mac.sv
// Multi-lane column PE: NUM_LANES MAC lanes, drain FSM and cascade adder.
// Define PE_VEC_MAC_SAT_EN for saturating arithmetic and a sticky ovf_o.
module pe_vec_mac
  import pe_pkg::*;
#(
  parameter int WIDTH_DATA  = 16,
  parameter int WIDTH_MDATA = 32,
  parameter int NUM_LANES   = 4,
  parameter int CNT_W       = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [1:0]                      mode_i,
  input  logic                            in_valid_i,
  input  logic [NUM_LANES*WIDTH_DATA-1:0] v_bus_data_i,
  input  logic [WIDTH_DATA-1:0]           h_bus_data_i,
  input  logic [WIDTH_MDATA-1:0]          top_data_i,
  input  logic                            top_valid_i,
  output logic [WIDTH_MDATA-1:0]          bot_data_o,
  output logic                            bot_valid_o,
  output logic                            busy_o,
  output logic [CNT_W-1:0]                mac_count_o,
  output logic                            ovf_o
);

  localparam int              LANE_W    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NUM_LANES - 1);

  pe_mode_e                      mode;
  pe_state_e                     state_q, state_d;
  logic [LANE_W-1:0]             lane_q, lane_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic signed [WIDTH_MDATA-1:0] bot_data_q;
  logic                          bot_valid_q, busy_q, ovf_q, ovf_d;
  logic                          mac_fire, bias_fire, drain_fire;
  logic [NUM_LANES-1:0]          lane_clr, lane_ovf;
  logic signed [WIDTH_MDATA-1:0] lane_acc [NUM_LANES];
  logic signed [WIDTH_MDATA-1:0] sel_acc, top_add, casc_sum;
  logic                          casc_clip;

  assign mode = pe_mode_e'(mode_i);

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    assign lane_clr[k] = drain_fire && (lane_q == LANE_W'(k));
    pe_mac_lane #(
      .WIDTH_DATA (WIDTH_DATA),
      .WIDTH_MDATA(WIDTH_MDATA)
    ) u_lane (
      .clk   (clk),
      .rst   (rst),
      .mac_i (mac_fire),
      .bias_i(bias_fire),
      .clr_i (lane_clr[k]),
      .v_i   (v_bus_data_i[k*WIDTH_DATA +: WIDTH_DATA]),
      .h_i   (h_bus_data_i),
      .acc_o (lane_acc[k]),
      .ovf_o (lane_ovf[k])
    );
  end

  // The first lane leaves on the same edge that samples DRAIN; the last lane's
  // edge returns to S_IDLE, so a new command is accepted on the following edge.
  always_comb begin
    state_d    = state_q;
    lane_d     = lane_q;
    cnt_d      = cnt_q;
    mac_fire   = 1'b0;
    bias_fire  = 1'b0;
    drain_fire = 1'b0;
    case (state_q)
      S_IDLE: begin
        mac_fire   = in_valid_i && (mode == MODE_MAC);
        bias_fire  = in_valid_i && (mode == MODE_BIAS);
        drain_fire = (mode == MODE_DRAIN);
      end
      S_DRAIN: drain_fire = 1'b1;
      default: state_d = S_IDLE;
    endcase
    if (mac_fire && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
    if (drain_fire) begin
      if (lane_q == LAST_LANE) begin
        state_d = S_IDLE;
        lane_d  = '0;
        cnt_d   = '0;
      end else begin
        state_d = S_DRAIN;
        lane_d  = lane_q + 1'b1;
      end
    end
  end

  always_comb begin
    sel_acc = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      if (lane_q == LANE_W'(k)) sel_acc = lane_acc[k];
    end
  end

  assign top_add = top_valid_i ? $signed(top_data_i) : '0;

`ifdef PE_VEC_MAC_SAT_EN
  sat_res_t casc_r;
  assign casc_r    = sat_add(SAT_MAX_W'(sel_acc), SAT_MAX_W'(top_add), WIDTH_MDATA);
  assign casc_sum  = casc_r.sum[WIDTH_MDATA-1:0];
  assign casc_clip = drain_fire && casc_r.clip;
`else
  assign casc_sum  = sel_acc + top_add;
  assign casc_clip = 1'b0;
`endif

  // In the wrapping build every clip source is constant 0, so ovf_q never sets.
  assign ovf_d = ovf_q | (|lane_ovf) | casc_clip;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      lane_q      <= '0;
      cnt_q       <= '0;
      bot_data_q  <= '0;
      bot_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      lane_q      <= lane_d;
      cnt_q       <= cnt_d;
      bot_valid_q <= drain_fire;
      busy_q      <= drain_fire;
      ovf_q       <= ovf_d;
      if (drain_fire) bot_data_q <= casc_sum;
    end
  end

  assign bot_data_o  = bot_data_q;
  assign bot_valid_o = bot_valid_q;
  assign busy_o      = busy_q;
  assign mac_count_o = cnt_q;
  assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_pe_vec_mac.sv
// Self-checking bench for pe_vec_mac: directed plan plus randomized beats
// checked against a transaction-level accumulator model.
module tb_pe_vec_mac;
  import pe_pkg::*;

  localparam int W  = 16;
  localparam int MW = 32;
  localparam int N  = 4;
  localparam int CW = 16;
  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]    mode0, mode1;
  logic          valid0, valid1;
  logic [N*W-1:0] v0, v1;
  logic [W-1:0]  h0, h1;
  logic [MW-1:0] top0;
  logic          topv0;
  logic [MW-1:0] bot0, bot1;
  logic          botv0, botv1, busy0, busy1, ovf0, ovf1;
  logic [CW-1:0] cnt0, cnt1;

  pe_vec_mac #(.WIDTH_DATA(W), .WIDTH_MDATA(MW), .NUM_LANES(N), .CNT_W(CW)) u_row0 (
    .clk(clk), .rst(rst), .mode_i(mode0), .in_valid_i(valid0), .v_bus_data_i(v0),
    .h_bus_data_i(h0), .top_data_i(top0), .top_valid_i(topv0), .bot_data_o(bot0),
    .bot_valid_o(botv0), .busy_o(busy0), .mac_count_o(cnt0), .ovf_o(ovf0)
  );

  pe_vec_mac #(.WIDTH_DATA(W), .WIDTH_MDATA(MW), .NUM_LANES(N), .CNT_W(CW)) u_row1 (
    .clk(clk), .rst(rst), .mode_i(mode1), .in_valid_i(valid1), .v_bus_data_i(v1),
    .h_bus_data_i(h1), .top_data_i(bot0), .top_valid_i(botv0), .bot_data_o(bot1),
    .bot_valid_o(botv1), .busy_o(busy1), .mac_count_o(cnt1), .ovf_o(ovf1)
  );

  int     n_tests = 0;
  int     n_fail  = 0;
  longint m_acc [N];
  int     m_cnt;
  bit     m_ovf;

  task automatic check(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Two's-complement result of the model's exact sum in the configured mode.
  function automatic longint fold(input longint x);
`ifdef PE_VEC_MAC_SAT_EN
    if (x > MAXV) begin m_ovf = 1'b1; return MAXV; end
    if (x < MINV) begin m_ovf = 1'b1; return MINV; end
    return x;
`else
    logic [31:0] t;
    t = x[31:0];
    return longint'($signed(t));
`endif
  endfunction

  function automatic int rnd_s16();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) m_acc[k] = 0;
    m_cnt = 0;
    m_ovf = 1'b0;
  endtask

  task automatic idle_inputs();
    mode0 = MODE_IDLE; valid0 = 1'b0; v0 = '0; h0 = '0; top0 = '0; topv0 = 1'b0;
    mode1 = MODE_IDLE; valid1 = 1'b0; v1 = '0; h1 = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mode0 = 2'($urandom_range(0, 3)); valid0 = 1'($urandom); v0 = {$urandom, $urandom};
    h0 = W'($urandom); top0 = $urandom; topv0 = 1'($urandom);
    mode1 = 2'($urandom_range(0, 3)); valid1 = 1'($urandom); v1 = {$urandom, $urandom};
    cyc();
    cyc();
    idle_inputs();
    rst = 1'b0;
    model_reset();
  endtask

  task automatic mac_beat(input int v [N], input int h);
    mode0 = MODE_MAC; valid0 = 1'b1; h0 = W'(h);
    for (int k = 0; k < N; k++) v0[k*W +: W] = W'(v[k]);
    cyc();
    for (int k = 0; k < N; k++) m_acc[k] = fold(m_acc[k] + longint'(v[k]) * longint'(h));
    if (m_cnt < 65535) m_cnt++;
    mode0 = MODE_IDLE; valid0 = 1'b0;
  endtask

  task automatic bias_beat(input int v [N]);
    mode0 = MODE_BIAS; valid0 = 1'b1;
    for (int k = 0; k < N; k++) v0[k*W +: W] = W'(v[k]);
    cyc();
    for (int k = 0; k < N; k++) m_acc[k] = fold(longint'(v[k]));
    mode0 = MODE_IDLE; valid0 = 1'b0;
  endtask

  task automatic drain(input string tag, input longint exp [N]);
    mode0 = MODE_DRAIN;
    for (int d = 0; d < N; d++) begin
      cyc();
      mode0 = MODE_IDLE;
      check($sformatf("%s_valid%0d", tag, d), 64'(botv0), 1);
      check($sformatf("%s_busy%0d", tag, d), 64'(busy0), 1);
      check($sformatf("%s_data%0d", tag, d), 64'($signed(bot0)), exp[d]);
    end
    cyc();
    check({tag, "_valid_end"}, 64'(botv0), 0);
    check({tag, "_busy_end"}, 64'(busy0), 0);
    check({tag, "_hold_end"}, 64'($signed(bot0)), exp[N-1]);
    check({tag, "_cnt_end"}, 64'(cnt0), 0);
    for (int k = 0; k < N; k++) m_acc[k] = 0;
    m_cnt = 0;
  endtask

  initial begin
    int     v [N];
    longint exp [N];

    idle_inputs();
    model_reset();

    // 1: reset with random inputs
    do_reset();
    check("rst_bot", 64'(bot0), 0);
    check("rst_valid", 64'(botv0), 0);
    check("rst_busy", 64'(busy0), 0);
    check("rst_cnt", 64'(cnt0), 0);
    check("rst_ovf", 64'(ovf0), 0);
    check("rst_bot1", 64'(bot1), 0);

    // 2: accumulate 16 beats and drain
    for (int i = 1; i <= 16; i++) begin
      for (int k = 0; k < N; k++) v[k] = (k + 1) * i;
      mac_beat(v, i);
    end
    check("acc_cnt", 64'(cnt0), 16);
    for (int k = 0; k < N; k++) exp[k] = 1496 * (k + 1);
    drain("acc", exp);

    // 3: bias then MAC, then an empty drain
    for (int k = 0; k < N; k++) v[k] = 20;
    bias_beat(v);
    check("bias_cnt", 64'(cnt0), 0);
    for (int k = 0; k < N; k++) v[k] = 2;
    for (int b = 0; b < 3; b++) mac_beat(v, 3);
    for (int k = 0; k < N; k++) exp[k] = 38;
    drain("bias", exp);
    for (int k = 0; k < N; k++) exp[k] = 0;
    drain("bias_empty", exp);

    // 4: two-row cascade, row1 drains one cycle after row0
    do_reset();
    mode0 = MODE_BIAS; valid0 = 1'b1; mode1 = MODE_BIAS; valid1 = 1'b1;
    for (int k = 0; k < N; k++) begin
      v0[k*W +: W] = W'(5);
      v1[k*W +: W] = W'(7);
    end
    cyc();
    mode0 = MODE_DRAIN; valid0 = 1'b0; mode1 = MODE_IDLE; valid1 = 1'b0;
    cyc();
    mode0 = MODE_IDLE; mode1 = MODE_DRAIN;
    for (int d = 0; d < N; d++) begin
      cyc();
      mode1 = MODE_IDLE;
      check($sformatf("casc_valid%0d", d), 64'(botv1), 1);
      check($sformatf("casc_data%0d", d), 64'($signed(bot1)), 12);
    end
    cyc();
    check("casc_valid_end", 64'(botv1), 0);
    check("casc_busy_end", 64'(busy1), 0);

    // 5: overflow of three maximal products
    do_reset();
    for (int k = 0; k < N; k++) v[k] = -32768;
    for (int b = 0; b < 3; b++) mac_beat(v, -32768);
`ifdef PE_VEC_MAC_SAT_EN
    for (int k = 0; k < N; k++) exp[k] = 2147483647;
    check("ovf_flag", 64'(ovf0), 1);
`else
    for (int k = 0; k < N; k++) exp[k] = -1073741824;
    check("ovf_flag", 64'(ovf0), 0);
`endif
    drain("ovf", exp);

    // 6: commands inside drain are ignored; reset mid-drain discards lanes
    do_reset();
    for (int b = 0; b < 3; b++) begin
      for (int k = 0; k < N; k++) v[k] = rnd_s16();
      mac_beat(v, rnd_s16());
    end
    for (int k = 0; k < N; k++) exp[k] = m_acc[k];
    mode0 = MODE_DRAIN;
    cyc();
    check("intf_data0", 64'($signed(bot0)), exp[0]);
    mode0 = MODE_MAC; valid0 = 1'b1; h0 = W'(1000);
    for (int k = 0; k < N; k++) v0[k*W +: W] = W'(1000);
    cyc();
    check("intf_cnt", 64'(cnt0), 3);
    check("intf_data1", 64'($signed(bot0)), exp[1]);
    mode0 = MODE_DRAIN;
    cyc();
    check("intf_data2", 64'($signed(bot0)), exp[2]);
    mode0 = MODE_BIAS;
    cyc();
    check("intf_data3", 64'($signed(bot0)), exp[3]);
    check("intf_cnt_clr", 64'(cnt0), 0);
    mode0 = MODE_IDLE; valid0 = 1'b0;
    cyc();
    check("intf_idle_valid", 64'(botv0), 0);
    for (int k = 0; k < N; k++) m_acc[k] = 0;
    m_cnt = 0;
    drain("intf_after", m_acc);

    for (int k = 0; k < N; k++) v[k] = rnd_s16() | 1;
    mac_beat(v, 7);
    mode0 = MODE_DRAIN;
    cyc();
    mode0 = MODE_IDLE;
    cyc();
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 64'(botv0), 0);
    check("mid_rst_busy", 64'(busy0), 0);
    check("mid_rst_bot", 64'(bot0), 0);
    check("mid_rst_cnt", 64'(cnt0), 0);
    #2;
    rst = 1'b0;
    model_reset();
    drain("mid_rst_after", m_acc);

    // Randomized beats against the model
    do_reset();
    for (int it = 0; it < 72; it++) begin
      for (int k = 0; k < N; k++) v[k] = rnd_s16();
      case ($urandom_range(0, 3))
        0: mac_beat(v, rnd_s16());
        1: bias_beat(v);
        2: begin
          mode0 = MODE_MAC; valid0 = 1'b0; h0 = W'($urandom);
          v0 = {$urandom, $urandom};
          cyc();
          mode0 = MODE_IDLE;
        end
        default: begin
          mode0 = MODE_IDLE; valid0 = 1'b1; v0 = {$urandom, $urandom};
          cyc();
          valid0 = 1'b0;
        end
      endcase
      if (it % 12 == 11) begin
        check($sformatf("rnd_cnt%0d", it), 64'(cnt0), 64'(m_cnt));
        drain($sformatf("rnd%0d", it), m_acc);
        check($sformatf("rnd_ovf%0d", it), 64'(ovf0), 64'(m_ovf));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pe_vec_mac.md
# pe_vec_mac

Multi-lane successor to the single-lane processing element. `NUM_LANES` signed MAC lanes share one broadcast horizontal operand and take one vertical operand per lane. A small FSM controls accumulate, bias-load and drain. During drain, the lane accumulators are serialised down a column cascade, and each lane result is summed with the partial sum arriving from the PE above. The block sits in a PE column; rows chain `bot_data_o` to the next PE's `top_data_i`.

## Interface
- `WIDTH_DATA`, 16, operand width, signed.
- `WIDTH_MDATA`, 32, accumulator and cascade width; must be >= 2*`WIDTH_DATA`.
- `NUM_LANES`, 4, number of parallel MAC lanes; must be >= 1.
- `CNT_W`, 16, width of the MAC beat counter.
- `clk` in 1: the single clock; all state updates on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `mode_i` in 2: command; 0 MAC, 1 BIAS, 2 DRAIN, 3 IDLE.
- `in_valid_i` in 1: qualifies MAC and BIAS beats.
- `v_bus_data_i` in `NUM_LANES`*`WIDTH_DATA`: per-lane vertical operand; lane k is bits [k*W +: W].
- `h_bus_data_i` in `WIDTH_DATA`: operand broadcast to all lanes.
- `top_data_i` in `WIDTH_MDATA`: partial sum from the PE above.
- `top_valid_i` in 1: qualifies `top_data_i`.
- `bot_data_o` out `WIDTH_MDATA`: registered cascade output.
- `bot_valid_o` out 1: qualifies `bot_data_o`.
- `busy_o` out 1: high while draining.
- `mac_count_o` out `CNT_W`: number of accepted MAC beats since the last drain.
- `ovf_o` out 1: sticky overflow flag (see Configuration).

## Operation
- FSM states: `S_IDLE`, `S_DRAIN`.
- `S_IDLE` handles MAC and BIAS beats. It moves to `S_DRAIN` when `mode_i`=DRAIN.
- **MAC beat** (`S_IDLE`, `mode_i`=MAC, `in_valid_i`=1):
  - Every lane does acc[k] += sext(v[k]*h), with a 2*`WIDTH_DATA` signed product.
  - `mac_count_o` increments and saturates at all-ones.
- **BIAS beat** (`S_IDLE`, `mode_i`=BIAS, `in_valid_i`=1):
  - Every lane does acc[k] <= sext(v[k]), overwriting the accumulator.
  - `mac_count_o` is unchanged.
- **IDLE, or `in_valid_i`=0:** accumulators hold.
- **DRAIN** (entered from `S_IDLE`):
  - An internal lane index d runs 0..`NUM_LANES`-1.
  - Each cycle: `bot_data_o` <= acc[d] + (`top_valid_i` ? `top_data_i` : 0), `bot_valid_o` <= 1, acc[d] <= 0.
  - After lane `NUM_LANES`-1 the FSM returns to `S_IDLE` and `mac_count_o` clears.
- **Inside `S_DRAIN`:** `mode_i` and `in_valid_i` are ignored, including a MAC beat, a BIAS beat or a repeated DRAIN command.
- **In `S_IDLE`:** `bot_data_o` holds its last value and `bot_valid_o`=0.
- **Cascade alignment:** the controller issues DRAIN to row r+1 exactly one cycle after row r. Lane k from every row then adds up at the bottom of the column.
- **Arithmetic:** two's complement throughout. The cascade add uses the same overflow rule as the accumulators.

## Timing
- **Reset values:** `bot_data_o`=0, `bot_valid_o`=0, `busy_o`=0, `mac_count_o`=0, `ovf_o`=0, all acc=0, state `S_IDLE`, d=0.
- **MAC/BIAS latency:** an update sampled at edge t is visible internally after edge t. A DRAIN sampled at t+1 includes it.
- **DRAIN command** sampled at edge t:
  - `busy_o`=1 from t through t+`NUM_LANES`-1.
  - Lane d appears on `bot_data_o` with `bot_valid_o`=1 after edge t+d.
  - `busy_o` returns to 0 after edge t+`NUM_LANES`.
- **`NUM_LANES`=1:** drain lasts one cycle. A DRAIN on the cycle the FSM returns to `S_IDLE` is accepted, so back-to-back drains are allowed.
- **Reset asserted mid-drain:** all outputs drop to reset values immediately. Remaining lanes are discarded.

## Configuration
- `PE_VEC_MAC_SAT_EN` defined:
  - Accumulate, bias and cascade adds saturate to the signed `WIDTH_MDATA` range.
  - `ovf_o` sets on any clipped result and clears only on reset.
- Not defined:
  - Results wrap modulo 2^`WIDTH_MDATA`.
  - `ovf_o` is tied to 0.

## Structure
- Package `pe_pkg` holds:
  - `pe_mode_e` enum (MAC=2'd0, BIAS=2'd1, DRAIN=2'd2, IDLE=2'd3).
  - `pe_state_e` enum (`S_IDLE`, `S_DRAIN`).
  - A saturating-add function shared by lanes and the cascade.
- Sub-module `pe_mac_lane` holds one accumulator with MAC, bias-load, clear and sat/wrap logic, and an overflow pulse output. The top level instantiates `NUM_LANES` of them with a generate loop and owns the FSM, counter, drain mux and cascade adder.

## Test plan
1. **Reset:** hold `rst`=1 with random inputs -> all outputs 0, `busy_o`=0.
2. **Accumulate and drain:** 16 MAC beats, i=1..16, with h=i and lane k v=(k+1)*i, then DRAIN -> `bot_data_o` = 1496, 2992, 4488, 5984 on 4 consecutive cycles.
   - `mac_count_o`=16 before the drain and 0 after.
3. **Bias then MAC:** BIAS with all v=20, then 3 MAC beats with v=2, h=3 -> drain gives 38 on every lane. A second drain gives 0 on every lane.
4. **Two-row cascade:** row0 acc=5 per lane and row1 acc=7 per lane; row1 `top_data_i` comes from row0's `bot_data_o`, and row1 drains one cycle after row0 -> row1 emits 12 four times.
5. **Overflow:** three MAC beats of v=h=-32768 (16/32-bit widths).
   - With `PE_VEC_MAC_SAT_EN`: acc=2147483647 and `ovf_o`=1.
   - Without it: acc=-1073741824 and `ovf_o`=0.
6. **Drain interference:** a MAC beat and a DRAIN during drain -> ignored, `mac_count_o` unchanged. `rst` pulsed at drain cycle 2 -> `bot_valid_o`=0 and `busy_o`=0 immediately.
